color_result_uart: RTL

- Downstream consumer of the red/green pixel judge's 2-bit `red_green` verdict.
- Debounces the verdict: it must hold a steady value for a programmable number of cycles before it is accepted.
- Latches each accepted verdict as the committed result and reports every change as one ASCII byte on an 8N1 UART TX line to the host or MCU.
- Sits between the colour judge and the board's serial pin.

---
 rtl/color_result_uart.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/color_result_uart.sv
// rtl/color_result_uart.sv - debounced red/green verdict latch with 8N1 UART change reporter
//
// Purpose : Debounces the 2-bit colour verdict and commits it as `result`. Every
//           committed change is sent as one ASCII byte ('N', 'R' or 'G') on an 8N1 UART line.
// Ports   : clk          system clock, rising edge
//           rst          asynchronous active-high reset
//           red_green    raw verdict: 00 none, 01 red, 10 green, 11 illegal
//           result       committed verdict
//           result_valid one-cycle pulse on every committed change
//           tx           UART serial output, idle high
//           busy         high while a frame (or CRLF tail) is on the line
// Option  : COLOR_UART_CRLF_EN - when defined, each code byte is followed by 0x0D 0x0A frames.

module color_result_uart #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int STABLE_CYC = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] red_green,
    output logic [1:0] result,
    output logic       result_valid,
    output logic       tx,
    output logic       busy
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int BW       = $clog2(BAUD_DIV);
    localparam int CW       = $clog2(STABLE_CYC);
    localparam logic [BW-1:0] BAUD_MAX = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    function automatic logic [7:0] code_byte(input logic [1:0] v);
        case (v)
            2'b01:   code_byte = 8'h52;
            2'b10:   code_byte = 8'h47;
            default: code_byte = 8'h4E;
        endcase
    endfunction

    // ---------------------------------------------------------------- debounce
    logic [1:0]    samp_q;
    logic [CW-1:0] cnt_q;
    logic          commit;

    // The illegal code never commits, so result keeps its previous value.
    assign commit = (cnt_q == CNT_MAX) && (samp_q != result) && (samp_q != 2'b11);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_q       <= 2'b00;
            cnt_q        <= '0;
            result       <= 2'b00;
            result_valid <= 1'b0;
        end else begin
            samp_q <= red_green;
            if (red_green != samp_q)
                cnt_q <= '0;
            else if (cnt_q != CNT_MAX)
                cnt_q <= cnt_q + 1'b1;
            result_valid <= commit;
            if (commit)
                result <= samp_q;
        end
    end

    // ------------------------------------------------------- pending + TX FSM
    tx_state_t     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          pend_q, pend_d;
    logic [7:0]    pend_byte_q, pend_byte_d;
    logic          load;
`ifdef COLOR_UART_CRLF_EN
    logic [1:0]    seq_q, seq_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            baud_q      <= '0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            pend_q      <= 1'b0;
            pend_byte_q <= 8'h00;
`ifdef COLOR_UART_CRLF_EN
            seq_q       <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            pend_q      <= pend_d;
            pend_byte_q <= pend_byte_d;
`ifdef COLOR_UART_CRLF_EN
            seq_q       <= seq_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        load    = 1'b0;
`ifdef COLOR_UART_CRLF_EN
        seq_d   = seq_q;
`endif
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = 3'd0;
                if (pend_q) begin
                    load    = 1'b1;
                    shift_d = pend_byte_q;
                    state_d = S_START;
`ifdef COLOR_UART_CRLF_EN
                    seq_d   = 2'd0;
`endif
                end
            end
            S_START: begin
                if (baud_q == BAUD_MAX) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_q == BAUD_MAX) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7)
                        state_d = S_STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                if (baud_q == BAUD_MAX) begin
                    baud_d = '0;
`ifdef COLOR_UART_CRLF_EN
                    // The CR/LF tail always finishes before a pending code byte goes out.
                    if (seq_q != 2'd2) begin
                        shift_d = (seq_q == 2'd0) ? 8'h0D : 8'h0A;
                        seq_d   = seq_q + 2'd1;
                        state_d = S_START;
                    end else if (pend_q) begin
                        load    = 1'b1;
                        shift_d = pend_byte_q;
                        seq_d   = 2'd0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
`else
                    // Back-to-back frame: no idle bit between stop and the next start.
                    if (pend_q) begin
                        load    = 1'b1;
                        shift_d = pend_byte_q;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
`endif
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
        endcase
    end

    // Single-entry slot: a commit always wins, even on the cycle the old byte is loaded.
    always_comb begin
        pend_d      = pend_q;
        pend_byte_d = pend_byte_q;
        if (load)
            pend_d = 1'b0;
        if (commit) begin
            pend_d      = 1'b1;
            pend_byte_d = code_byte(samp_q);
        end
    end

    // Decoded from state flops so reset forces the line high without waiting for a clock.
    always_comb begin
        tx = 1'b1;
        case (state_q)
            S_START: tx = 1'b0;
            S_DATA:  tx = shift_q[0];
            default: tx = 1'b1;
        endcase
    end

    assign busy = (state_q != S_IDLE);

endmodule
